fifo_burst_drain: RTL and testbench
===================================

// Module: fifo_burst_drain
// PURPOSE
//  Read-side controller for the single-clock FIFO. Watches the occupancy count and empty flag.
//  Issues rd_en pulses in bursts of BURST_LEN words.
//  Absorbs the FIFO's 1-cycle registered read latency in a 2-entry skid buffer.
//  Presents the data as a valid/ready stream with a last-word marker for the downstream packet consumer.
// PARAMETERS
//  DATA_W     8    FIFO word width (matches FIFO buf_out)
//  CNT_W      8    width of FIFO occupancy count
//  BURST_LEN  16   words per normal burst; legal range 1..2**CNT_W-1
// PORTS
//  clk           in   1       clock, all logic on rising edge
//  rst           in   1       reset, asynchronous, active-high
//  buf_out       in   DATA_W  FIFO read data, valid 1 cycle after an accepted rd_en
//  buf_empty     in   1       FIFO empty flag
//  fifo_counter  in   CNT_W   FIFO occupancy
//  rd_en         out  1       FIFO read strobe; never high while buf_empty=1
//  flush         in   1       level; drain a short (<BURST_LEN) residue when set in IDLE
//  m_data        out  DATA_W  stream data (head of skid buffer)
//  m_valid       out  1       stream valid
//  m_ready       in   1       stream ready; transfer when m_valid&m_ready
//  m_last        out  1       high with the final word of each burst
//  busy          out  1       high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rd_en=0, m_valid=0, m_data=0, m_last=0, busy=0, all counters/occupancy=0.
//    Reset mid-burst discards buffered and in-flight words; the FIFO side is not rewound.
//  FSM IDLE -> BURST: fifo_counter>=BURST_LEN latches blen=BURST_LEN.
//    Otherwise flush=1 and buf_empty=0 latches blen=fifo_counter. Registered; rd_en may assert from the next cycle.
//  FSM BURST -> DRAIN: when issued==blen, i.e. the last read has been issued.
//  FSM DRAIN -> IDLE: when skid occupancy==0, inflight==0 and the last word has been transferred.
//  flush is ignored outside IDLE. fifo_counter is sampled only on the IDLE->BURST edge.
//  rd_en (combinational) = state==BURST & !buf_empty & issued<blen & (occ+inflight<2 | pop), where pop=m_valid&m_ready.
//  inflight: register set to rd_en. The following cycle buf_out is written into the skid buffer tail.
//  Skid buffer: 2-entry FIFO, occ 0..2; push and pop in the same cycle are allowed.
//    occ+inflight never exceeds 2, so there is no overflow and no data is dropped.
//  Throughput: with m_ready held high and the FIFO non-empty, rd_en stays high every cycle of BURST (1 word/clk).
//  Latency: first rd_en to first m_valid = 2 cycles (FIFO register + skid write).
//  m_data/m_valid hold stable while m_valid=1 and m_ready=0.
//  buf_empty=1 during BURST: rd_en deasserts, the FSM stays in BURST, and the burst resumes when data arrives.
//  m_last: output counter sent (CNT_W bits) increments on pop. m_last=m_valid & (sent==blen-1).
//    sent clears on DRAIN->IDLE.
//  Arithmetic: issued/sent are CNT_W-bit and never wrap, because blen<=2**CNT_W-1.
// TESTING
//  1 rst, fifo_counter=20, m_ready=1 -> 16 consecutive rd_en pulses; 16 words out in order;
//    m_last on word 16; IDLE; new burst only while counter>=16.
//  2 fifo_counter=5, flush=1 -> exactly 5 rd_en, 5 words out, m_last on word 5, busy falls after it.
//  3 m_ready toggled 1/0 each cycle during burst -> never occ>2; no lost or duplicate words;
//    m_data stable while stalled.
//  4 buf_empty forced high for 3 cycles mid-burst -> rd_en low for those cycles;
//    burst completes with 16 words and one m_last.
//  5 rst asserted async mid-burst (occ=2) -> m_valid, rd_en, busy low immediately; after release IDLE with occ=0.
//  6 m_ready=0 from burst start -> rd_en stops after 2 reads; releasing m_ready gives full-rate resume.

Source files
------------

// File: rtl/fifo_burst_drain.sv
// rtl/fifo_burst_drain.sv - burst read controller for the single-clock FIFO with a 2-entry skid buffer
// Reads BURST_LEN words (or a flushed residue) per burst and presents them as a valid/ready stream with m_last.
module fifo_burst_drain #(
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 8,
    parameter int BURST_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] buf_out,
    input  logic              buf_empty,
    input  logic [CNT_W-1:0]  fifo_counter,
    output logic              rd_en,
    input  logic              flush,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy
);

    localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   blen_q, blen_d;
    logic [CNT_W-1:0]   issued_q, issued_d;
    logic [CNT_W-1:0]   sent_q, sent_d;
    logic               inflight_q, inflight_d;
    logic [1:0]         occ_q, occ_d;
    logic [DATA_W-1:0]  e0_q, e0_d;
    logic [DATA_W-1:0]  e1_q, e1_d;
    logic               pop;
    logic               push;

    assign m_valid = (occ_q != 2'd0);
    assign m_data  = e0_q;
    assign pop     = m_valid & m_ready;
    assign push    = inflight_q;
    assign busy    = (state_q != IDLE);
    assign m_last  = m_valid & (sent_q == (blen_q - CNT_W'(1)));

    // A read may issue only if its word is guaranteed a skid slot when it lands.
    assign rd_en = (state_q == BURST) & ~buf_empty & (issued_q < blen_q) &
                   (((occ_q + {1'b0, inflight_q}) < 2'd2) | pop);

    always_comb begin
        state_d    = state_q;
        blen_d     = blen_q;
        issued_d   = issued_q;
        sent_d     = sent_q;
        inflight_d = rd_en;
        occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
        e0_d       = e0_q;
        e1_d       = e1_q;

        if (pop) begin
            e0_d = e1_q;
            sent_d = sent_q + CNT_W'(1);
        end
        if (push) begin
            if ((occ_q - {1'b0, pop}) == 2'd0) begin
                e0_d = buf_out;
            end else begin
                e1_d = buf_out;
            end
        end
        if (rd_en) begin
            issued_d = issued_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                issued_d = '0;
                if (fifo_counter >= BURST_LEN_C) begin
                    blen_d  = BURST_LEN_C;
                    state_d = BURST;
                end else if (flush && !buf_empty) begin
                    blen_d  = fifo_counter;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (issued_q == blen_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((occ_q == 2'd0) && !inflight_q && (sent_q == blen_q)) begin
                    sent_d  = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            blen_q     <= '0;
            issued_q   <= '0;
            sent_q     <= '0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            e0_q       <= '0;
            e1_q       <= '0;
        end else begin
            state_q    <= state_d;
            blen_q     <= blen_d;
            issued_q   <= issued_d;
            sent_q     <= sent_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            e0_q       <= e0_d;
            e1_q       <= e1_d;
        end
    end

endmodule

// File: tb/tb_fifo_burst_drain.sv
// tb/tb_fifo_burst_drain.sv - directed bench for fifo_burst_drain against a behavioural FIFO model
// The FIFO returns its read-pointer value as data, so stream order is checked by a running counter.
module tb_fifo_burst_drain;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] buf_out = 8'd0;
    logic       buf_empty;
    logic [7:0] fifo_counter;
    logic       rd_en;
    logic       flush = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic       m_last;
    logic       busy;

    int wr_ptr = 0;
    int rd_ptr = 0;
    logic force_empty = 1'b0;

    int checks = 0;
    int passes = 0;
    int rd_cnt = 0;
    int out_cnt = 0;
    int last_cnt = 0;
    int last_at = 0;
    int exp_word = 0;
    logic stall_prev = 1'b0;
    logic [7:0] prev_data = 8'd0;

    always #5 clk = ~clk;

    fifo_burst_drain #(.DATA_W(8), .CNT_W(8), .BURST_LEN(16)) dut (
        .clk(clk), .rst(rst), .buf_out(buf_out), .buf_empty(buf_empty),
        .fifo_counter(fifo_counter), .rd_en(rd_en), .flush(flush),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .busy(busy)
    );

    assign fifo_counter = ((wr_ptr - rd_ptr) > 255) ? 8'd255 : 8'(wr_ptr - rd_ptr);
    assign buf_empty    = (wr_ptr == rd_ptr) | force_empty;

    // Registered-read FIFO: data appears the cycle after an accepted rd_en; reset does not rewind it.
    always @(posedge clk) begin
        if (rd_en) begin
            buf_out <= 8'(rd_ptr);
            rd_ptr  <= rd_ptr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_word   = rd_ptr;
            stall_prev = 1'b0;
        end else begin
            if (rd_en) begin
                rd_cnt++;
                chk("rd_en_while_empty", 32'(buf_empty), 32'd0);
                chk("skid_occ_bound", 32'(dut.occ_q <= 2'd2), 32'd1);
            end
            if (stall_prev) begin
                chk("stall_valid_hold", 32'(m_valid), 32'd1);
                chk("stall_data_hold", 32'(m_data), 32'(prev_data));
            end
            if (m_valid && m_ready) begin
                chk("data_order", 32'(m_data), 32'(8'(exp_word)));
                if (m_last) begin
                    last_cnt++;
                    last_at = out_cnt + 1;
                end
                out_cnt++;
                exp_word++;
            end
            stall_prev = m_valid & ~m_ready;
            prev_data  = m_data;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rd(input string tag);
        int n = 0;
        while (!rd_en && n < 100) begin
            cyc(1);
            n++;
        end
        chk(tag, 32'(rd_en), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 400) begin
            cyc(1);
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic chk_burst(input string tag, input int r0, input int o0, input int l0, input int words);
        chk({tag, "_rd_count"}, 32'(rd_cnt - r0), 32'(words));
        chk({tag, "_word_count"}, 32'(out_cnt - o0), 32'(words));
        chk({tag, "_last_count"}, 32'(last_cnt - l0), 32'd1);
        chk({tag, "_last_pos"}, 32'(last_at - o0), 32'(words));
    endtask

    initial begin
        int r0, o0, l0, cnt;

        // Reset state and full-rate 16-word burst from a 20-word FIFO.
        wr_ptr  = 20;
        m_ready = 1'b1;
        #1;
        chk("reset_rd_en", 32'(rd_en), 32'd0);
        chk("reset_m_valid", 32'(m_valid), 32'd0);
        chk("reset_m_data", 32'(m_data), 32'd0);
        chk("reset_m_last", 32'(m_last), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        cyc(2);
        rst = 1'b0;
        r0 = rd_cnt; o0 = out_cnt; l0 = last_cnt;
        wait_rd("t1_start");
        for (int i = 0; i < 16; i++) begin
            chk("t1_rd_run", 32'(rd_en), 32'd1);
            chk("t1_latency", 32'(m_valid), 32'(i >= 2));
            cyc(1);
        end
        chk("t1_rd_stop", 32'(rd_en), 32'd0);
        wait_idle("t1_idle");
        chk_burst("t1", r0, o0, l0, 16);
        cyc(5);
        chk("t1_no_short_burst", 32'(busy), 32'd0);
        chk("t1_residue", 32'(fifo_counter), 32'd4);

        // Flushed residue of 5 words.
        wr_ptr = wr_ptr + 1;
        r0 = rd_cnt; o0 = out_cnt; l0 = last_cnt;
        flush = 1'b1;
        wait_rd("t2_start");
        wait_idle("t2_idle");
        flush = 1'b0;
        chk_burst("t2", r0, o0, l0, 5);
        cyc(3);
        chk("t2_stay_idle", 32'(busy), 32'd0);

        // m_ready toggling every cycle.
        wr_ptr = wr_ptr + 16;
        r0 = rd_cnt; o0 = out_cnt; l0 = last_cnt;
        cnt = 0;
        cyc(1);
        while ((busy || cnt == 0) && cnt < 400) begin
            m_ready = ~m_ready;
            cyc(1);
            cnt++;
        end
        m_ready = 1'b1;
        chk("t3_idle", 32'(busy), 32'd0);
        chk_burst("t3", r0, o0, l0, 16);

        // FIFO empty for 3 cycles mid-burst.
        wr_ptr = wr_ptr + 16;
        r0 = rd_cnt; o0 = out_cnt; l0 = last_cnt;
        cnt = 0;
        while ((rd_cnt - r0) < 5 && cnt < 100) begin
            cyc(1);
            cnt++;
        end
        force_empty = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("t4_rd_gap", 32'(rd_en), 32'd0);
            chk("t4_busy_hold", 32'(busy), 32'd1);
            cyc(1);
        end
        force_empty = 1'b0;
        wait_idle("t4_idle");
        chk_burst("t4", r0, o0, l0, 16);

        // Asynchronous reset with the skid buffer full.
        m_ready = 1'b0;
        wr_ptr = wr_ptr + 16;
        cnt = 0;
        while (dut.occ_q != 2'd2 && cnt < 100) begin
            cyc(1);
            cnt++;
        end
        chk("t5_occ_full", 32'(dut.occ_q), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_m_valid", 32'(m_valid), 32'd0);
        chk("t5_async_rd_en", 32'(rd_en), 32'd0);
        chk("t5_async_busy", 32'(busy), 32'd0);
        cyc(1);
        rst = 1'b0;
        cyc(3);
        chk("t5_occ_clear", 32'(dut.occ_q), 32'd0);
        chk("t5_idle", 32'(busy), 32'd0);
        chk("t5_no_valid", 32'(m_valid), 32'd0);

        // Stalled consumer from burst start, then full-rate resume.
        wr_ptr = wr_ptr + 2;
        r0 = rd_cnt; o0 = out_cnt; l0 = last_cnt;
        wait_rd("t6_start");
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cnt += int'(rd_en);
            cyc(1);
        end
        chk("t6_stalled_reads", 32'(cnt), 32'd2);
        m_ready = 1'b1;
        #1;
        for (int i = 0; i < 14; i++) begin
            chk("t6_resume_rate", 32'(rd_en), 32'd1);
            cyc(1);
        end
        wait_idle("t6_idle");
        chk_burst("t6", r0, o0, l0, 16);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
